// File: rtl/nvsram_pkg.sv
// rtl/nvsram_pkg.sv - shared types and helpers for the nvSRAM array model
package nvsram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STORE,
        SWAIT,
        RECALL
    } nv_state_t;

    // Zero-extension never changes parity, so one wide helper serves any word width.
    localparam int PAR_MAX_W = 1024;

    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/nvsram_xfer_ctrl.sv
// rtl/nvsram_xfer_ctrl.sv - store/recall sequencer: FSM, index and wait counters, copy strobes
module nvsram_xfer_ctrl
    import nvsram_pkg::*;
#(
    parameter int DEPTH     = 136,
    parameter int STORE_LAT = 16,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hs,
    input  logic          hr,
    output logic          busy,
    output logic          nvc_done,
    output logic          store_en,
    output logic          recall_en,
    output logic [AW-1:0] idx
);

    localparam int WW = (STORE_LAT > 1) ? $clog2(STORE_LAT) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [WW-1:0] LAST_W   = WW'((STORE_LAT > 0) ? STORE_LAT - 1 : 0);

    nv_state_t     state, state_nx;
    logic [AW-1:0] idx_nx;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic          done_nx;

    // Reset lands in RECALL so every power-up refreshes the SRAM from the NV array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RECALL;
            idx      <= '0;
            wcnt     <= '0;
            nvc_done <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            wcnt     <= wcnt_nx;
            nvc_done <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        wcnt_nx  = wcnt;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nx = STORE;
                    idx_nx   = '0;
                end else if (hr) begin
                    state_nx = RECALL;
                    idx_nx   = '0;
                end
            end
            STORE: begin
                if (idx == LAST_IDX) begin
                    idx_nx  = '0;
                    wcnt_nx = '0;
                    if (STORE_LAT > 0) begin
                        state_nx = SWAIT;
                    end else begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            SWAIT: begin
                if (wcnt == LAST_W) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    wcnt_nx = wcnt + 1'b1;
                end
            end
            RECALL: begin
                if (idx == LAST_IDX) begin
                    idx_nx   = '0;
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign store_en  = (state == STORE);
    assign recall_en = (state == RECALL);

endmodule

// File: rtl/nvsram_array.sv
// rtl/nvsram_array.sv - SRAM shadowed by NV array with store/recall; parity via NVSRAM_PARITY_EN
module nvsram_array
    import nvsram_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 136,
    parameter int STORE_LAT = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             POR,
    input  logic             CE,
    input  logic             WE,
    input  logic [AW-1:0]    A,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             RDY,
    input  logic             HS,
    input  logic             HR,
    output logic             BUSYNVC,
    output logic             NVC_DONE
`ifdef NVSRAM_PARITY_EN
   ,output logic             PERR
`endif
);

`ifdef NVSRAM_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [SW-1:0] sram  [DEPTH];
    logic [SW-1:0] nvram [DEPTH];

    logic          store_en, recall_en, access, in_range;
    logic [AW-1:0] idx;
    logic [SW-1:0] wword, rword;

    nvsram_xfer_ctrl #(
        .DEPTH     (DEPTH),
        .STORE_LAT (STORE_LAT),
        .AW        (AW)
    ) u_ctrl (
        .clk       (CLK),
        .rst       (POR),
        .hs        (HS),
        .hr        (HR),
        .busy      (BUSYNVC),
        .nvc_done  (NVC_DONE),
        .store_en  (store_en),
        .recall_en (recall_en),
        .idx       (idx)
    );

    // Store/recall requests win over a same-cycle access, which is then dropped.
    assign access   = CE && !BUSYNVC && !HS && !HR;
    assign in_range = ({1'b0, A} < DEPTH_W);
    assign rword    = sram[A];

`ifdef NVSRAM_PARITY_EN
    assign wword = {even_parity(PAR_MAX_W'(DIN)), DIN};
`else
    assign wword = DIN;
`endif

    // Arrays are never reset: their contents must survive POR.
    always_ff @(posedge CLK) begin
        if (access && WE && in_range) begin
            sram[A] <= wword;
        end else if (recall_en) begin
            sram[idx] <= nvram[idx];
        end
        if (store_en) begin
            nvram[idx] <= sram[idx];
        end
    end

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            DOUT <= '0;
            RDY  <= 1'b0;
`ifdef NVSRAM_PARITY_EN
            PERR <= 1'b0;
`endif
        end else begin
            RDY <= access;
            if (access) begin
                if (in_range) begin
                    DOUT <= rword[WIDTH-1:0];
`ifdef NVSRAM_PARITY_EN
                    PERR <= ^rword;
`endif
                end else begin
                    DOUT <= '0;
`ifdef NVSRAM_PARITY_EN
                    PERR <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_nvsram_array.sv
// tb/tb_nvsram_array.sv - scoreboard bench for nvsram_array (optionally with NVSRAM_PARITY_EN)
module tb_nvsram_array;

    localparam int D  = 136;
    localparam int SL = 16;

    logic        CLK = 1'b0;
    logic        POR, CE, WE, HS, HR;
    logic [7:0]  A;
    logic [31:0] DIN, DOUT;
    logic        RDY, BUSYNVC, NVC_DONE;
`ifdef NVSRAM_PARITY_EN
    logic        PERR;
    localparam int SWB = 33;
`else
    localparam int SWB = 32;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [31:0] q[$];
    logic [31:0] sm[D];
    logic [31:0] nm[D];
    logic [31:0] nw[D];

    always #5 CLK = ~CLK;

    nvsram_array #(.WIDTH(32), .DEPTH(D), .STORE_LAT(SL)) dut (
        .CLK      (CLK),
        .POR      (POR),
        .CE       (CE),
        .WE       (WE),
        .A        (A),
        .DIN      (DIN),
        .DOUT     (DOUT),
        .RDY      (RDY),
        .HS       (HS),
        .HR       (HR),
        .BUSYNVC  (BUSYNVC),
        .NVC_DONE (NVC_DONE)
`ifdef NVSRAM_PARITY_EN
       ,.PERR     (PERR)
`endif
    );

    function automatic logic [SWB-1:0] enc(input logic [31:0] v);
`ifdef NVSRAM_PARITY_EN
        return {^v, v};
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic acc(input logic we, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp);
        CE = 1'b1; WE = we; A = a; DIN = d;
        q.push_back(exp);
        @(negedge CLK);
    endtask

    task automatic idle();
        CE = 1'b0; WE = 1'b0; HS = 1'b0; HR = 1'b0;
    endtask

    task automatic pulse(input logic hs, input logic hr);
        CE = 1'b0; WE = 1'b0; HS = hs; HR = hr;
        @(negedge CLK);
        HS = 1'b0; HR = 1'b0;
    endtask

    // Counts cycles with BUSYNVC high starting at the current negedge; optionally
    // pokes HR plus a write to A=7 mid-sequence, both of which must be ignored.
    task automatic wait_busy(input int poke, input int exp_cycles, input string name);
        int cnt = 0;
        int rdy_seen = 0;
        while (BUSYNVC === 1'b1 && cnt < 4000) begin
            cnt++;
            if (RDY !== 1'b0) rdy_seen++;
            if (cnt == poke) begin
                CE = 1'b1; WE = 1'b1; HR = 1'b1; A = 8'd7; DIN = 32'hFFFF_FFFF;
            end else if (cnt == poke + 1) begin
                CE = 1'b0; WE = 1'b0; HR = 1'b0;
            end
            @(negedge CLK);
        end
        check(name, 64'(cnt), 64'(exp_cycles));
        check({name, "_done"}, 64'(NVC_DONE), 64'd1);
        check({name, "_rdy"}, 64'(rdy_seen), 64'd0);
    endtask

    always @(negedge CLK) begin
        if (RDY === 1'b1) begin
            if (q.size() == 0) check("stray_rdy", 64'd1, 64'd0);
            else check("dout", 64'(DOUT), 64'(q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        POR = 1'b0; idle(); A = '0; DIN = '0;
        #1 POR = 1'b1;
        for (int i = 0; i < D; i++) begin
            nm[i] = 32'hA500_0000 | 32'(i);
            sm[i] = '0;
            dut.nvram[i] = enc(nm[i]);
            dut.sram[i]  = enc(32'd0);
        end
        repeat (3) @(negedge CLK);
        check("rst_dout", 64'(DOUT), 64'd0);
        check("rst_rdy", 64'(RDY), 64'd0);
        check("rst_busy", 64'(BUSYNVC), 64'd1);
        check("rst_done", 64'(NVC_DONE), 64'd0);

        POR = 1'b0;
        wait_busy(-1, D, "por_recall");
        for (int i = 0; i < D; i++) sm[i] = nm[i];
        acc(1'b0, 8'd5, 32'd0, 32'hA500_0005);

        acc(1'b1, 8'd3, 32'hDEAD_BEEF, 32'hA500_0003);
        acc(1'b0, 8'd3, 32'd0, 32'hDEAD_BEEF);
        sm[3] = 32'hDEAD_BEEF;

        for (int i = 0; i < D; i++) begin
            logic [31:0] d;
            d = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
            acc(1'b1, 8'(i), d, sm[i]);
            sm[i] = d;
        end
        pulse(1'b1, 1'b0);
        wait_busy(-1, D + SL, "store");
        for (int i = 0; i < D; i++) nm[i] = sm[i];
        check("nv_store_0", 64'(dut.nvram[0][31:0]), 64'(nm[0]));
        check("nv_store_135", 64'(dut.nvram[135][31:0]), 64'(nm[135]));

        for (int i = 0; i < D; i++) dut.sram[i] = enc(32'd0);
        pulse(1'b0, 1'b1);
        wait_busy(-1, D, "recall");
        for (int i = 0; i < D; i++) acc(1'b0, 8'(i), 32'd0, nm[i]);
        idle();

        pulse(1'b1, 1'b1);
        wait_busy(10, D + SL, "hs_hr_store");
        acc(1'b0, 8'd7, 32'd0, sm[7]);
        idle();

        for (int i = 0; i < D; i++) begin
            nw[i] = 32'hC0DE_0000 | 32'(i);
            dut.sram[i] = enc(nw[i]);
        end
        @(negedge CLK);
        pulse(1'b1, 1'b0);
        repeat (40) @(negedge CLK);
        POR = 1'b1;
        @(negedge CLK);
        check("abort_nv_0", 64'(dut.nvram[0][31:0]), 64'(nw[0]));
        check("abort_nv_39", 64'(dut.nvram[39][31:0]), 64'(nw[39]));
        check("abort_nv_40", 64'(dut.nvram[40][31:0]), 64'(nm[40]));
        check("abort_nv_135", 64'(dut.nvram[135][31:0]), 64'(nm[135]));
        check("abort_dout", 64'(DOUT), 64'd0);
        for (int i = 0; i < 40; i++) nm[i] = nw[i];
        POR = 1'b0;
        wait_busy(-1, D, "abort_recall");
        for (int i = 0; i < D; i++) sm[i] = nm[i];
        acc(1'b0, 8'd0, 32'd0, nm[0]);
        acc(1'b0, 8'd39, 32'd0, nm[39]);
        acc(1'b0, 8'd40, 32'd0, nm[40]);
        acc(1'b0, 8'd135, 32'd0, nm[135]);

        acc(1'b0, 8'd200, 32'd0, 32'd0);
        acc(1'b1, 8'd200, 32'hFFFF_FFFF, 32'd0);
        acc(1'b0, 8'd135, 32'd0, sm[135]);

`ifdef NVSRAM_PARITY_EN
        dut.sram[9] = dut.sram[9] ^ 33'h1;
        acc(1'b0, 8'd9, 32'd0, sm[9] ^ 32'h1);
        check("perr_set", 64'(PERR), 64'd1);
        acc(1'b0, 8'd10, 32'd0, sm[10]);
        check("perr_clear", 64'(PERR), 64'd0);
`endif
        idle();
        repeat (3) @(negedge CLK);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
